param_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO; successor of the fixed 16x8 synchronous FIFO.

---
 rtl/param_fifo_pkg.sv | 45 ++++
 rtl/param_fifo_ctrl.sv | 98 +++++++++
 rtl/param_sync_fifo.sv | 101 ++++++++++
 tb/tb_param_sync_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
// Exports fifo_op_e (accepted-operation decode) and fifo_status_s (flag bundle).
package param_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;
    localparam int STAT_CNT_W     = 16;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    typedef struct packed {
        logic                  full;
        logic                  empty;
        logic                  almostfull;
        logic                  almostempty;
        logic [STAT_CNT_W-1:0] count;
    } fifo_status_s;

    // PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1)
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic fifo_op_e op_decode(input logic wr_acc,
                                           input logic rd_acc);
        fifo_op_e op;
        unique case ({wr_acc, rd_acc})
            2'b10:   op = OP_WR;
            2'b01:   op = OP_RD;
            2'b11:   op = OP_RW;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/param_fifo_ctrl.sv
// FIFO control: pointers, occupancy count, status flags, registered ack/error flags.
// Ports: i_clk, i_rst (async high), i_wr_en, i_rd_en -> o_wr_ptr, o_rd_ptr, o_op,
//        o_status, o_wr_ack, o_overflow, o_underflow, o_err_sticky.
module param_fifo_ctrl
    import param_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AF_TH = DEPTH - 1,
    parameter int AE_TH = 1,
    parameter int PTR_W = ptr_w(DEPTH),
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output fifo_op_e         o_op,
    output fifo_status_s     o_status,
    output logic             o_wr_ack,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_err_sticky
);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_TH);
    localparam logic [PTR_W-1:0] P_LAST  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_wr_ack;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_err;

    logic     w_full;
    logic     w_empty;
    logic     w_ovf;
    logic     w_udf;
    fifo_op_e w_op;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_ovf   = i_wr_en & w_full;
    assign w_udf   = i_rd_en & w_empty;
    assign w_op    = op_decode(i_wr_en & ~w_full, i_rd_en & ~w_empty);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // explicit wrap compare keeps non-power-of-2 depths correct
            if (w_op == OP_WR || w_op == OP_RW) begin
                r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_op == OP_RD || w_op == OP_RW) begin
                r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            unique case (w_op)
                OP_WR:   r_count <= r_count + CNT_W'(1);
                OP_RD:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_wr_ack    <= (w_op == OP_WR || w_op == OP_RW);
            r_overflow  <= w_ovf;
            r_underflow <= w_udf;
            r_err       <= r_err | w_ovf | w_udf;
        end
    end

    assign o_wr_ptr     = r_wr_ptr;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_op         = w_op;
    assign o_wr_ack     = r_wr_ack;
    assign o_overflow   = r_overflow;
    assign o_underflow  = r_underflow;
    assign o_err_sticky = r_err;

    always_comb begin
        o_status             = '0;
        o_status.full        = w_full;
        o_status.empty       = w_empty;
        o_status.almostfull  = (r_count >= C_AF);
        o_status.almostempty = !w_empty && (r_count <= C_AE);
        o_status.count       = STAT_CNT_W'(r_count);
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO: storage array and read-data path around param_fifo_ctrl.
// Ports: clk, rst (async high), wr_en, rd_en, data_in -> data_out, wr_ack, overflow,
//        underflow, err_sticky, full, empty, almostfull, almostempty, count.
// Build option: PARAM_FIFO_FWFT_EN selects first-word-fall-through read data.
module param_sync_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_TH      = DEPTH - 1,
    parameter int AE_TH      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      wr_ack,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      err_sticky,
    output logic                      full,
    output logic                      empty,
    output logic                      almostfull,
    output logic                      almostempty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be >= 2");
    end
    if (AF_TH > DEPTH || AF_TH < 1) begin : g_bad_af
        $error("param_sync_fifo: AF_TH must lie in 1..DEPTH");
    end
    if (AE_TH >= DEPTH) begin : g_bad_ae
        $error("param_sync_fifo: AE_TH must be < DEPTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    fifo_op_e         w_op;
    fifo_status_s     w_status;

    param_fifo_ctrl #(
        .DEPTH (DEPTH),
        .AF_TH (AF_TH),
        .AE_TH (AE_TH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_rd_en      (rd_en),
        .o_wr_ptr     (w_wr_ptr),
        .o_rd_ptr     (w_rd_ptr),
        .o_op         (w_op),
        .o_status     (w_status),
        .o_wr_ack     (wr_ack),
        .o_overflow   (overflow),
        .o_underflow  (underflow),
        .o_err_sticky (err_sticky)
    );

    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_op == OP_WR || w_op == OP_RW) begin
            r_mem[w_wr_ptr] <= data_in;
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    // head of queue is visible without a read; zero while empty
    assign data_out = w_status.empty ? '0 : r_mem[w_rd_ptr];
`else
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_op == OP_RD || w_op == OP_RW) begin
            r_dout <= r_mem[w_rd_ptr];
        end
    end

    assign data_out = r_dout;
`endif

    assign full        = w_status.full;
    assign empty       = w_status.empty;
    assign almostfull  = w_status.almostfull;
    assign almostempty = w_status.almostempty;
    assign count       = CNT_W'(w_status.count);

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: DEPTH=8 default instance and a DEPTH=5 instance.
// Works for both the registered-read and PARAM_FIFO_FWFT_EN builds.
module tb_param_sync_fifo;

    logic        clk;
    logic        rst;

    logic        wr8, rd8, wr5, rd5;
    logic [15:0] din8, din5, dout8, dout5;
    logic        ack8, ovf8, udf8, err8, full8, empty8, af8, ae8;
    logic        ack5, ovf5, udf5, err5, full5, empty5, af5, ae5;
    logic [3:0]  cnt8;
    logic [2:0]  cnt5;

    int n_chk = 0;
    int n_err = 0;

    param_sync_fifo u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr8),
        .rd_en       (rd8),
        .data_in     (din8),
        .data_out    (dout8),
        .wr_ack      (ack8),
        .overflow    (ovf8),
        .underflow   (udf8),
        .err_sticky  (err8),
        .full        (full8),
        .empty       (empty8),
        .almostfull  (af8),
        .almostempty (ae8),
        .count       (cnt8)
    );

    param_sync_fifo #(
        .DATA_WIDTH (16),
        .DEPTH      (5),
        .AF_TH      (4),
        .AE_TH      (1)
    ) u_dut5 (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr5),
        .rd_en       (rd5),
        .data_in     (din5),
        .data_out    (dout5),
        .wr_ack      (ack5),
        .overflow    (ovf5),
        .underflow   (udf5),
        .err_sticky  (err5),
        .full        (full5),
        .empty       (empty5),
        .almostfull  (af5),
        .almostempty (ae5),
        .count       (cnt5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {full, empty, af, ae, ack, ovf, udf, err}
    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [15:0] dout;
        logic [15:0] dout_fwft;
        int          cnt;
        logic [7:0]  fl;
    } vec_t;

    vec_t tv [19];

    logic [15:0] q8 [$];
    logic [15:0] q5 [$];
    logic [15:0] rv8, rv5;
    bit          e8, e5;

    function automatic vec_t mk(input logic wr, input logic rd,
                                input logic [15:0] din,
                                input logic [15:0] dout,
                                input logic [15:0] dfw,
                                input int cnt, input logic [7:0] fl);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din;
        v.dout = dout; v.dout_fwft = dfw;
        v.cnt = cnt; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // one cycle on either instance, expectations from a queue model
    task automatic step(input bit s5, input bit wr, input bit rd,
                        input logic [15:0] din, input string tag);
        logic [15:0] q [$];
        logic [15:0] rdv, edout;
        int          dep, afth;
        bit          fl, em, ack, ovf, udf, err;
        dep  = s5 ? 5 : 8;
        afth = s5 ? 4 : 7;
        if (s5) begin q = q5; rdv = rv5; err = e5; end
        else    begin q = q8; rdv = rv8; err = e8; end
        fl  = (q.size() == dep);
        em  = (q.size() == 0);
        ack = wr && !fl;
        ovf = wr && fl;
        udf = rd && em;
        if (rd && !em) rdv = q.pop_front();
        if (ack) q.push_back(din);
        err = err | ovf | udf;
        if (s5) begin wr5 = wr; rd5 = rd; din5 = din; end
        else    begin wr8 = wr; rd8 = rd; din8 = din; end
        tick();
        wr5 = 1'b0; rd5 = 1'b0; wr8 = 1'b0; rd8 = 1'b0;
`ifdef PARAM_FIFO_FWFT_EN
        edout = (q.size() != 0) ? q[0] : 16'h0;
`else
        edout = rdv;
`endif
        chk({tag, ".count"}, s5 ? int'(cnt5) : int'(cnt8), q.size());
        chk({tag, ".dout"}, s5 ? int'(dout5) : int'(dout8), int'(edout));
        chk({tag, ".flags"},
            s5 ? int'({full5, empty5, af5, ae5, ack5, ovf5, udf5, err5})
               : int'({full8, empty8, af8, ae8, ack8, ovf8, udf8, err8}),
            int'({(q.size() == dep), (q.size() == 0), (q.size() >= afth),
                  (q.size() == 1), ack, ovf, udf, err}));
        if (s5) begin q5 = q; rv5 = rdv; e5 = err; end
        else    begin q8 = q; rv8 = rdv; e8 = err; end
    endtask

    initial begin
        rst = 1'b1;
        wr8 = 1'b0; rd8 = 1'b0; din8 = '0;
        wr5 = 1'b0; rd5 = 1'b0; din5 = '0;
        rv8 = '0; rv5 = '0; e8 = 1'b0; e5 = 1'b0;

        // T2 then T3: fill, overflow, drain, underflow
        tv[0]  = mk(1, 0, 16'h0001, 16'h0000, 16'h0001, 1, 8'b0001_1000);
        tv[1]  = mk(1, 0, 16'h0002, 16'h0000, 16'h0001, 2, 8'b0000_1000);
        tv[2]  = mk(1, 0, 16'h0003, 16'h0000, 16'h0001, 3, 8'b0000_1000);
        tv[3]  = mk(1, 0, 16'h0004, 16'h0000, 16'h0001, 4, 8'b0000_1000);
        tv[4]  = mk(1, 0, 16'h0005, 16'h0000, 16'h0001, 5, 8'b0000_1000);
        tv[5]  = mk(1, 0, 16'h0006, 16'h0000, 16'h0001, 6, 8'b0000_1000);
        tv[6]  = mk(1, 0, 16'h0007, 16'h0000, 16'h0001, 7, 8'b0010_1000);
        tv[7]  = mk(1, 0, 16'h0008, 16'h0000, 16'h0001, 8, 8'b1010_1000);
        tv[8]  = mk(1, 0, 16'h0009, 16'h0000, 16'h0001, 8, 8'b1010_0101);
        tv[9]  = mk(0, 1, 16'h0000, 16'h0001, 16'h0002, 7, 8'b0010_0001);
        tv[10] = mk(0, 1, 16'h0000, 16'h0002, 16'h0003, 6, 8'b0000_0001);
        tv[11] = mk(0, 1, 16'h0000, 16'h0003, 16'h0004, 5, 8'b0000_0001);
        tv[12] = mk(0, 1, 16'h0000, 16'h0004, 16'h0005, 4, 8'b0000_0001);
        tv[13] = mk(0, 1, 16'h0000, 16'h0005, 16'h0006, 3, 8'b0000_0001);
        tv[14] = mk(0, 1, 16'h0000, 16'h0006, 16'h0007, 2, 8'b0000_0001);
        tv[15] = mk(0, 1, 16'h0000, 16'h0007, 16'h0008, 1, 8'b0001_0001);
        tv[16] = mk(0, 1, 16'h0000, 16'h0008, 16'h0000, 0, 8'b0100_0001);
        tv[17] = mk(0, 1, 16'h0000, 16'h0008, 16'h0000, 0, 8'b0100_0011);
        tv[18] = mk(0, 0, 16'h0000, 16'h0008, 16'h0000, 0, 8'b0100_0001);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst.count8", cnt8, 0);
        chk("rst.dout8", dout8, 0);
        chk("rst.flags8", {full8, empty8, af8, ae8, ack8, ovf8, udf8, err8},
            8'b0100_0000);
        chk("rst.count5", cnt5, 0);
        chk("rst.flags5", {full5, empty5, af5, ae5, ack5, ovf5, udf5, err5},
            8'b0100_0000);

        for (int i = 0; i < 19; i++) begin
            wr8 = tv[i].wr; rd8 = tv[i].rd; din8 = tv[i].din;
            tick();
            wr8 = 1'b0; rd8 = 1'b0;
            chk($sformatf("tv%0d.count", i), cnt8, tv[i].cnt);
`ifdef PARAM_FIFO_FWFT_EN
            chk($sformatf("tv%0d.dout", i), dout8, tv[i].dout_fwft);
`else
            chk($sformatf("tv%0d.dout", i), dout8, tv[i].dout);
`endif
            chk($sformatf("tv%0d.flags", i),
                {full8, empty8, af8, ae8, ack8, ovf8, udf8, err8}, tv[i].fl);
        end
        q8.delete();
        rv8 = 16'h0008;
        e8  = 1'b1;

        // T4: DEPTH=5, 13 writes with interleaved reads, pointers wrap
        for (int i = 1; i <= 5; i++) step(1, 1, 0, 16'(i), "t4.w");
        chk("t4.full5", full5, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 16'h0, "t4.r");
        for (int i = 6; i <= 8; i++) step(1, 1, 0, 16'(i), "t4.w");
        for (int i = 0; i < 5; i++) step(1, 0, 1, 16'h0, "t4.r");
        chk("t4.empty5", empty5, 1);
        for (int i = 9; i <= 13; i++) step(1, 1, 0, 16'(i), "t4.w");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 16'h0, "t4.r");
        chk("t4.ae5_at1", ae5, 1);
        chk("t4.af5_at1", af5, 0);

        // T5: simultaneous requests on DUT8 (currently empty)
        step(0, 1, 1, 16'h00A1, "t5.rw_empty");
        chk("t5.udf_empty", udf8, 1);
        chk("t5.ack_empty", ack8, 1);
        step(0, 1, 0, 16'h00A2, "t5.w");
        step(0, 1, 0, 16'h00A3, "t5.w");
        for (int i = 0; i < 10; i++) step(0, 1, 1, 16'h00B0 + 16'(i), "t5.rw");
        chk("t5.count_held", cnt8, 3);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h00C0 + 16'(i), "t5.fill");
        step(0, 1, 1, 16'h00D0, "t5.rw_full");
        chk("t5.ovf_full", ovf8, 1);
        chk("t5.count_full", cnt8, 7);
        step(0, 0, 1, 16'h0, "t5.r");
        step(0, 0, 1, 16'h0, "t5.r");

        // T1: asynchronous reset mid-stream with count=5
        chk("t1.pre_count", cnt8, 5);
        #2 rst = 1'b1;
        #1;
        chk("t1.count", cnt8, 0);
        chk("t1.empty", empty8, 1);
        chk("t1.flags", {ack8, ovf8, udf8, err8}, 4'b0000);
        chk("t1.dout", dout8, 0);
        @(negedge clk);
        rst = 1'b0;
        q8.delete(); q5.delete();
        rv8 = '0; rv5 = '0; e8 = 1'b0; e5 = 1'b0;
        step(0, 1, 0, 16'h1234, "t1.post_w");
        step(0, 0, 1, 16'h0, "t1.post_r");

`ifdef PARAM_FIFO_FWFT_EN
        // T6: fall-through visibility and zero when empty
        step(0, 1, 0, 16'hBEEF, "t6.w");
        chk("t6.dout_head", dout8, 16'hBEEF);
        step(0, 0, 1, 16'h0, "t6.r");
        chk("t6.empty", empty8, 1);
        chk("t6.dout_zero", dout8, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
